// File: rtl/craft_job_arbiter.sv
// ---------------------------------------------------------------------------
// craft_job_arbiter
//
// Purpose:
//   Shares one craft_encrypt core between two requesters using round-robin
//   arbitration. The core has no start input, so each job restarts it by
//   holding core_rst_n low for RST_CYCLES cycles while the granted operands
//   are already stable on core_*. When core_done rises, the ciphertext is
//   captured and returned with the requester ID on a valid/ready response
//   channel. Only one job is in flight at a time.
//
// Handshake semantics (both channels):
//   A transfer happens on a rising clk edge where valid && ready are both 1.
//   The producer holds valid and its payload stable until that edge. Ready
//   may depend combinationally on valid; valid never depends on ready.
//
// Optional feature:
//   Define CRAFT_ARB_TIMEOUT_EN to enable the RUN watchdog. The job is
//   aborted with rsp_err=1 and rsp_data=0 if core_done has not been seen by
//   the MAX_CYCLES-th RUN cycle. Without the macro, RUN waits indefinitely
//   and rsp_err is tied to 0.
//
// Parameters:
//   RST_CYCLES  cycles core_rst_n is held low per job (>=1)
//   MAX_CYCLES  watchdog limit in RUN cycles (used with CRAFT_ARB_TIMEOUT_EN)
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/ready     per-requester job handshake (bit i = requester i)
//   req_plaintext       requester i at [i*64 +: 64]
//   req_tweak           requester i at [i*64 +: 64]
//   req_key             requester i at [i*128 +: 128]
//   rsp_valid/ready     result handshake
//   rsp_id/data/err     requester index, ciphertext, watchdog abort flag
//   busy                1 whenever a job is in flight (state != IDLE)
//   core_*              connection to the craft_encrypt instance
//   dbg_state           current FSM state (IDLE=0, LOAD=1, RUN=2, RESP=3)
// ---------------------------------------------------------------------------
module craft_job_arbiter #(
  parameter int RST_CYCLES = 2,
  parameter int MAX_CYCLES = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [127:0] req_plaintext,
  input  logic [127:0] req_tweak,
  input  logic [255:0] req_key,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [63:0]  rsp_data,
  output logic         rsp_err,
  output logic         busy,
  output logic         core_rst_n,
  output logic [63:0]  core_plaintext,
  output logic [63:0]  core_tweak,
  output logic [127:0] core_key,
  input  logic         core_done,
  input  logic [63:0]  core_ciphertext,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  // Width of the LOAD down-counter; it runs from RST_CYCLES-1 to 0.
  localparam int LCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  if (RST_CYCLES < 1 || MAX_CYCLES < 1) begin : g_param_check
    $error("craft_job_arbiter: RST_CYCLES and MAX_CYCLES must be >= 1");
  end

  state_t           r_state;
  state_t           w_next;
  logic             r_ptr;
  logic [LCW-1:0]   r_load_cnt;
  logic             r_core_rst_n;
  logic [63:0]      r_core_pt;
  logic [63:0]      r_core_tw;
  logic [127:0]     r_core_key;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [63:0]      r_rsp_data;

  logic             w_winner;
  logic [1:0]       w_req_ready;
  logic [63:0]      w_win_pt;
  logic [63:0]      w_win_tw;
  logic [127:0]     w_win_key;

`ifdef CRAFT_ARB_TIMEOUT_EN
  localparam int TCW = ($clog2(MAX_CYCLES + 1) > 8) ? $clog2(MAX_CYCLES + 1) : 8;
  logic [TCW-1:0]   r_run_cnt;
  logic             r_rsp_err;
  logic             w_timeout;

  // r_run_cnt is 0 on the first RUN cycle, so this fires on RUN cycle MAX_CYCLES.
  assign w_timeout = (r_run_cnt == TCW'(MAX_CYCLES - 1));
`endif

  // Round-robin: a lone requester always wins; on contention the pointer decides.
  assign w_winner  = (req_valid == 2'b11) ? r_ptr : req_valid[1];
  assign w_win_pt  = w_winner ? req_plaintext[127:64] : req_plaintext[63:0];
  assign w_win_tw  = w_winner ? req_tweak[127:64]     : req_tweak[63:0];
  assign w_win_key = w_winner ? req_key[255:128]      : req_key[127:0];

  // Next-state and request acceptance
  always_comb begin
    w_next      = r_state;
    w_req_ready = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (req_valid != 2'b00) begin
          w_req_ready[w_winner] = 1'b1;
          w_next                = S_LOAD;
        end
      end
      S_LOAD: begin
        if (r_load_cnt == '0) w_next = S_RUN;
      end
      S_RUN: begin
        if (core_done) w_next = S_RESP;
`ifdef CRAFT_ARB_TIMEOUT_EN
        else if (w_timeout) w_next = S_RESP;
`endif
      end
      S_RESP: begin
        if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr        <= 1'b0;
      r_load_cnt   <= '0;
      r_core_rst_n <= 1'b0;
      r_core_pt    <= '0;
      r_core_tw    <= '0;
      r_core_key   <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_data   <= '0;
`ifdef CRAFT_ARB_TIMEOUT_EN
      r_run_cnt    <= '0;
      r_rsp_err    <= 1'b0;
`endif
    end else begin
      // Registered so the core sees a clean reset edge; high exactly while in RUN.
      r_core_rst_n <= (w_next == S_RUN);
      case (r_state)
        S_IDLE: begin
          if (req_valid != 2'b00) begin
            r_core_pt  <= w_win_pt;
            r_core_tw  <= w_win_tw;
            r_core_key <= w_win_key;
            r_rsp_id   <= w_winner;
            r_ptr      <= ~w_winner;
            r_load_cnt <= LCW'(RST_CYCLES - 1);
          end
        end
        S_LOAD: begin
          if (r_load_cnt != '0) r_load_cnt <= r_load_cnt - LCW'(1);
`ifdef CRAFT_ARB_TIMEOUT_EN
          r_run_cnt <= '0;
`endif
        end
        S_RUN: begin
          if (core_done) begin
            r_rsp_data  <= core_ciphertext;
            r_rsp_valid <= 1'b1;
`ifdef CRAFT_ARB_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
          end else if (w_timeout) begin
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
          end else begin
            r_run_cnt   <= r_run_cnt + TCW'(1);
`endif
          end
        end
        S_RESP: begin
          if (rsp_ready) r_rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign req_ready      = w_req_ready;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_id         = r_rsp_id;
  assign rsp_data       = r_rsp_data;
`ifdef CRAFT_ARB_TIMEOUT_EN
  assign rsp_err        = r_rsp_err;
`else
  assign rsp_err        = 1'b0;
`endif
  assign busy           = (r_state != S_IDLE);
  assign core_rst_n     = r_core_rst_n;
  assign core_plaintext = r_core_pt;
  assign core_tweak     = r_core_tw;
  assign core_key       = r_core_key;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_craft_job_arbiter.sv
// ---------------------------------------------------------------------------
// tb_craft_job_arbiter
//
// Drives two requesters into craft_job_arbiter with a stub core
// (done on the 12th cycle after core_rst_n rises, ciphertext = pt ^ tweak).
// A monitor predicts each grant from the round-robin rule, queues the
// expected response and its latency, and checks every response, core
// operand stability, core_rst_n timing and busy against that model.
// ---------------------------------------------------------------------------
module tb_craft_job_arbiter;
  localparam int RST_CYCLES = 2;
  localparam int MAX_CYCLES = 64;
  localparam int DONE_AT    = 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [127:0] req_plaintext;
  logic [127:0] req_tweak;
  logic [255:0] req_key;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [63:0]  rsp_data;
  logic         rsp_err;
  logic         busy;
  logic         core_rst_n;
  logic [63:0]  core_plaintext;
  logic [63:0]  core_tweak;
  logic [127:0] core_key;
  logic         core_done;
  logic [63:0]  core_ciphertext;
  logic [1:0]   dbg_state;

  craft_job_arbiter #(.RST_CYCLES(RST_CYCLES), .MAX_CYCLES(MAX_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_plaintext(req_plaintext), .req_tweak(req_tweak), .req_key(req_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .core_rst_n(core_rst_n), .core_plaintext(core_plaintext),
    .core_tweak(core_tweak), .core_key(core_key),
    .core_done(core_done), .core_ciphertext(core_ciphertext),
    .dbg_state(dbg_state)
  );

  // ---------------- stub core ----------------
  int   stub_cnt;
  logic stub_hang;
  always @(posedge clk or negedge core_rst_n) begin
    if (!core_rst_n)          stub_cnt <= 0;
    else if (stub_cnt < 5000) stub_cnt <= stub_cnt + 1;
  end
  assign core_done       = core_rst_n && !stub_hang && (stub_cnt >= DONE_AT - 1);
  assign core_ciphertext = core_plaintext ^ core_tweak;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [65:0] exp_q[$];   // {err, id, data}
  int          lat_q[$];
  int          grant_log[$];

  int           cyc = 0;
  logic         m_busy = 1'b0;
  logic         m_ptr  = 1'b0;
  int           g_cyc  = 0;
  int           g_lat  = 0;
  logic [63:0]  g_pt, g_tw;
  logic [127:0] g_key;
  logic         prev_v = 1'b0;
  logic         prev_hs = 1'b0;
  logic         h_id, h_err;
  logic [63:0]  h_data;
  int           n_rsp = 0;
  logic         last_id, last_err;
  logic [63:0]  last_data;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic        pred;
    logic [65:0] e;
    int          l;
    cyc++;
    if (!rst_n) begin
      m_busy = 1'b0; m_ptr = 1'b0; g_lat = 0;
      exp_q.delete(); lat_q.delete();
      prev_v = 1'b0; prev_hs = 1'b0;
    end else begin
      chk("busy", busy, m_busy);
      chk("core_rst_n", core_rst_n,
          m_busy && ((cyc - g_cyc) > RST_CYCLES) && ((cyc - g_cyc) < g_lat));
      if (m_busy) begin
        chk("core_plaintext", core_plaintext, g_pt);
        chk("core_tweak", core_tweak, g_tw);
        chk("core_key", core_key, g_key);
      end
      if (!m_busy && req_valid != 2'b00) begin
        pred = (req_valid == 2'b11) ? m_ptr : req_valid[1];
        chk("req_ready_grant", req_ready, pred ? 2'b10 : 2'b01);
        g_pt  = pred ? req_plaintext[127:64] : req_plaintext[63:0];
        g_tw  = pred ? req_tweak[127:64]     : req_tweak[63:0];
        g_key = pred ? req_key[255:128]      : req_key[127:0];
        g_cyc = cyc; m_busy = 1'b1; m_ptr = ~pred;
        grant_log.push_back(int'(pred));
        if (!stub_hang) begin
          g_lat = RST_CYCLES + DONE_AT + 1;
          exp_q.push_back({1'b0, pred, g_pt ^ g_tw});
          lat_q.push_back(g_lat);
        end else begin
`ifdef CRAFT_ARB_TIMEOUT_EN
          g_lat = RST_CYCLES + MAX_CYCLES + 1;
          exp_q.push_back({1'b1, pred, 64'h0});
          lat_q.push_back(g_lat);
`else
          g_lat = 1 << 30;
`endif
        end
      end else begin
        chk("req_ready_zero", req_ready, 2'b00);
      end
      if (rsp_valid) begin
        if (prev_hs) begin
          chk("rsp_clear_after_hs", rsp_valid, 1'b0);
        end else if (!prev_v) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL rsp_unexpected actual id=%0d data=%h expected=no response", rsp_id, rsp_data);
          end else begin
            e = exp_q.pop_front();
            l = lat_q.pop_front();
            chk("rsp_id", rsp_id, e[64]);
            chk("rsp_data", rsp_data, e[63:0]);
            chk("rsp_err", rsp_err, e[65]);
            chk("rsp_latency", cyc - g_cyc, l);
          end
          h_id = rsp_id; h_data = rsp_data; h_err = rsp_err;
          last_id = rsp_id; last_data = rsp_data; last_err = rsp_err;
        end else begin
          chk("rsp_id_stable", rsp_id, h_id);
          chk("rsp_data_stable", rsp_data, h_data);
          chk("rsp_err_stable", rsp_err, h_err);
        end
        if (rsp_ready && !prev_hs) begin
          m_busy = 1'b0;
          n_rsp++;
        end
      end else if (prev_v && !prev_hs) begin
        chk("rsp_dropped", rsp_valid, 1'b1);
      end
      prev_v  = rsp_valid;
      prev_hs = rsp_valid && rsp_ready;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic new_op(input int i);
    if (i == 0) begin
      req_plaintext[63:0] = {$urandom, $urandom};
      req_tweak[63:0]     = {$urandom, $urandom};
      req_key[127:0]      = {$urandom, $urandom, $urandom, $urandom};
    end else begin
      req_plaintext[127:64] = {$urandom, $urandom};
      req_tweak[127:64]     = {$urandom, $urandom};
      req_key[255:128]      = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  // mode 0: steady valid, rsp_ready=1
  // mode 1: random valid drops and random rsp_ready
  // mode 2: rsp_ready withheld for 10 cycles of each response
  task automatic run_jobs(input int n0, input int n1, input int mode);
    int left[2];
    int budget;
    int target;
    int bp;
    logic [1:0] acc;
    logic rv;
    left[0] = n0; left[1] = n1;
    budget  = (n0 + n1) * 120 + 200;
    target  = n_rsp + n0 + n1;
    bp      = 0;
    rsp_ready = (mode == 0);
    while (n_rsp < target && budget > 0) begin
      @(negedge clk);
      acc = req_ready & req_valid;
      rv  = rsp_valid;
      @(posedge clk); #1;
      budget--;
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) begin
          left[i]--;
          new_op(i);  // scramble inputs right after acceptance
        end
        req_valid[i] = (left[i] > 0) && ((mode != 1) || ($urandom_range(0, 3) != 0));
      end
      if (mode == 1) begin
        rsp_ready = ($urandom_range(0, 1) == 1);
      end else if (mode == 2) begin
        if (rv && rsp_ready) begin
          bp = 0; rsp_ready = 1'b0;
        end else if (rv) begin
          bp++;
          rsp_ready = (bp >= 10);
        end
      end
    end
    chk("job_budget", budget > 0, 1'b1);
    req_valid = 2'b00;
    rsp_ready = 1'b1;
  endtask

  task automatic wait_grant(input int i);
    int n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (req_ready[i]) break;
      n++;
    end
    chk("grant_seen", n < 50, 1'b1);
    @(posedge clk); #1;
    req_valid = 2'b00;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_core_rst_n", core_rst_n, 1'b0);
    chk("rst_busy", busy, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; stub_hang = 1'b0;
    req_valid = 2'b00; rsp_ready = 1'b1;
    req_plaintext = '0; req_tweak = '0; req_key = '0;
    new_op(0); new_op(1);

    repeat (3) @(negedge clk);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_rsp_id", rsp_id, 1'b0);
    chk("reset_rsp_data", rsp_data, 64'h0);
    chk("reset_rsp_err", rsp_err, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_core_rst_n", core_rst_n, 1'b0);
    chk("reset_core_pt", core_plaintext, 64'h0);
    chk("reset_core_tw", core_tweak, 64'h0);
    chk("reset_core_key", core_key, 128'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // single directed job
    req_plaintext[63:0] = 64'h5734F006D8D88A3E;
    req_tweak[63:0]     = 64'h54CD94FFD0670A58;
    req_key[127:0]      = 128'h27a6781a43f364bc916708d5fbb5aefe;
    run_jobs(1, 0, 0);
    chk("single_id", last_id, 1'b0);
    chk("single_data", last_data, 64'h03F964F908BF8066);
    chk("single_err", last_err, 1'b0);

    // reset during RUN: job from req0 leaves the pointer at 1 before reset
    new_op(0);
    req_valid = 2'b01;
    wait_grant(0);
    repeat (6) @(posedge clk);
    pulse_reset();
    repeat (20) @(negedge clk);
    chk("dropped_no_rsp", rsp_valid, 1'b0);
    chk("dropped_idle", busy, 1'b0);

    // contention: pointer restarts at 0, grants alternate
    grant_log.delete();
    run_jobs(4, 4, 0);
    chk("contention_count", grant_log.size(), 8);
    for (int k = 0; k < grant_log.size(); k++)
      chk($sformatf("contention_grant%0d", k), grant_log[k], k % 2);

    // backpressure with a pending requester
    run_jobs(1, 2, 2);

    // randomized traffic
    run_jobs(8, 8, 1);

    // hung core
    stub_hang = 1'b1;
`ifdef CRAFT_ARB_TIMEOUT_EN
    run_jobs(1, 0, 0);
    chk("timeout_err", last_err, 1'b1);
    chk("timeout_data", last_data, 64'h0);
`else
    new_op(0);
    req_valid = 2'b01;
    wait_grant(0);
    repeat (1000) @(negedge clk);
    chk("hang_no_rsp", rsp_valid, 1'b0);
    chk("hang_busy", busy, 1'b1);
    pulse_reset();
`endif
    stub_hang = 1'b0;
    repeat (3) @(negedge clk);
    chk("exp_q_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=still running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
